div_job_sequencer: RTL and testbench

Upstream feeder for the restoring divider (`restoringDivider`: 12-bit dividend, 6-bit divisor, 6-bit quotient, 7-bit remainder, `start`/`done`).
- Accepts division jobs on a valid/ready input, buffers them in a small FIFO, and screens each job for divide-by-zero and quotient overflow.
- Launches legal jobs on the divider and holds operands stable until `done` rises.
- Returns every result, computed or bypassed, on a valid/ready output with status flags and a timeout guard.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_job_fifo.sv | 39 +++
 rtl/div_job_sequencer.sv | 125 ++++++++++++
 tb/tb_div_job_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM states and saturation constants for the divider job sequencer
package div_pkg;
  localparam int DVD_W = 12;
  localparam int DVS_W = 6;
  localparam int QUO_W = 6;
  localparam int REM_W = 7;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;
  localparam logic [QUO_W-1:0] QUO_SAT = 6'h3F;
  localparam logic [REM_W-1:0] REM_SAT = 7'h7F;
endpackage

// File: rtl/div_job_fifo.sv
// div_job_fifo: synchronous job FIFO with registered occupancy count
module div_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  // entry storage; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/div_job_sequencer.sv
// div_job_sequencer: buffers division jobs, screens them, drives the restoring divider and returns results
module div_job_sequencer
  import div_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] in_dividend,
  input  logic [DVS_W-1:0] in_divisor,
  output logic [DVD_W-1:0] div_dividend,
  output logic [DVS_W-1:0] div_divisor,
  output logic             div_start,
  input  logic [QUO_W-1:0] div_quotient,
  input  logic [REM_W-1:0] div_rem,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QUO_W-1:0] out_quotient,
  output logic [REM_W-1:0] out_rem,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             out_timeout,
  output logic             busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic full, empty, pop, done_q, done_rise, dbz, ovf, ld_div, ld_res;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [DVD_W+DVS_W-1:0] head;
  logic [DVD_W-1:0] hd_dvd;
  logic [DVS_W-1:0] hd_dvs;
  logic [QUO_W-1:0] res_q;
  logic [REM_W-1:0] res_r;
  logic [2:0] res_f;
  div_job_fifo #(.DEPTH(FIFO_DEPTH), .W(DVD_W + DVS_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid),
    .pop(pop),
    .wdata({in_dividend, in_divisor}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign {hd_dvd, hd_dvs} = head;
  assign dbz = hd_dvs == '0;
  assign ovf = ~dbz & (hd_dvd[DVD_W-1:DVS_W] >= hd_dvs);
  assign done_rise = div_done & ~done_q;
  assign in_ready = ~full;
  assign div_start = state == LAUNCH;
  assign out_valid = state == RESULT;
  assign busy = (state != IDLE) | (count != '0);
  // next state, counter and load strobes; result defaults are the saturated timeout values
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pop = 1'b0;
    ld_div = 1'b0;
    ld_res = 1'b0;
    res_q = QUO_SAT;
    res_r = REM_SAT;
    res_f = 3'b000;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        cnt_n = '0;
        if (dbz | ovf) begin
          state_n = RESULT;
          ld_res = 1'b1;
          res_r = dbz ? 7'h00 : REM_SAT;
          res_f = {dbz, ovf, 1'b0};
        end else begin
          state_n = LAUNCH;
          ld_div = 1'b1;
        end
      end
      LAUNCH: begin
        state_n = (cnt == CW'(1)) ? WAIT : LAUNCH;
        cnt_n = (cnt == CW'(1)) ? '0 : cnt + CW'(1);
      end
      WAIT: if (done_rise) begin
        state_n = RESULT;
        ld_res = 1'b1;
        res_q = div_quotient;
        res_r = div_rem;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = RESULT;
        ld_res = 1'b1;
        res_f = 3'b001;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      RESULT: state_n = out_ready ? IDLE : RESULT;
      default: state_n = IDLE;
    endcase
  end
  // state, counters, operand and result registers; done_q tracks div_done continuously for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      out_quotient <= '0;
      out_rem <= '0;
      {out_dbz, out_ovf, out_timeout} <= 3'b000;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done_q <= div_done;
      if (ld_div) {div_dividend, div_divisor} <= head;
      if (ld_res) begin
        out_quotient <= res_q;
        out_rem <= res_r;
        {out_dbz, out_ovf, out_timeout} <= res_f;
      end
    end
endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer: table vectors, corner-case sequences and random jobs against an arithmetic reference
module tb_div_job_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic in_valid = 0;
  logic in_ready;
  logic [11:0] in_dividend = 0;
  logic [5:0] in_divisor = 0;
  logic [11:0] div_dividend;
  logic [5:0] div_divisor;
  logic div_start;
  logic [5:0] div_quotient;
  logic [6:0] div_rem;
  logic div_done;
  logic out_valid, out_ready;
  logic [5:0] out_quotient;
  logic [6:0] out_rem;
  logic out_dbz, out_ovf, out_timeout, busy;

  div_job_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_quotient(div_quotient), .div_rem(div_rem), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_rem(out_rem),
    .out_dbz(out_dbz), .out_ovf(out_ovf), .out_timeout(out_timeout), .busy(busy)
  );

  int n_chk = 0, n_fail = 0, start_cnt = 0, n_out = 0;

  // divider model: computes the answer at launch, raises done lat cycles after start drops
  int lat = 1, mcnt = 0;
  bit hang = 0, manual = 0, man_done = 0, mdl_done = 0, pending = 0;
  logic [5:0] mq = 0;
  logic [6:0] mr = 0;
  assign div_done = manual ? man_done : mdl_done;
  assign div_quotient = mq;
  assign div_rem = mr;
  always begin
    @(posedge clk);
    #1;
    if (div_start) begin
      mdl_done = 0;
      pending = 1;
      mcnt = lat;
      if (div_divisor != 0) begin
        mq = 6'(div_dividend / div_divisor);
        mr = 7'(div_dividend % div_divisor);
      end
    end else if (pending && !hang) begin
      if (mcnt == 0) begin
        mdl_done = 1;
        pending = 0;
      end else mcnt--;
    end
  end

  bit rnd_on = 0, rnd_bit = 0, ready_drv = 0;
  assign out_ready = rnd_on ? rnd_bit : ready_drv;
  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  typedef struct {logic [11:0] a; logic [5:0] b;} job_t;
  job_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // reference: {quotient, rem, dbz, ovf, timeout} from plain arithmetic
  function automatic logic [15:0] ref_res(input job_t j, input bit to);
    if (j.b == 0) return {6'h3F, 7'h00, 3'b100};
    if (int'(j.a) >= 64 * int'(j.b)) return {6'h3F, 7'h7F, 3'b010};
    if (to) return {6'h3F, 7'h7F, 3'b001};
    return {6'(j.a / j.b), 7'(j.a % j.b), 3'b000};
  endfunction

  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (rst_n && in_valid && in_ready) sb.push_back('{in_dividend, in_divisor});
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("scoreboard", {out_quotient, out_rem, out_dbz, out_ovf, out_timeout}, ref_res(sb.pop_front(), hang));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [5:0] b);
    int n = 0;
    in_valid = 1;
    in_dividend = a;
    in_divisor = b;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("push_wait", 1, 0);
    tick();
    in_valid = 0;
  endtask

  task automatic collect(output logic [15:0] res);
    int n = 0;
    while (!out_valid && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("out_valid_wait", 1, 0);
    res = {out_quotient, out_rem, out_dbz, out_ovf, out_timeout};
    ready_drv = 1;
    tick();
    ready_drv = 0;
  endtask

  task automatic drain(input string nm, input int want);
    int n = 0;
    while (n_out < want && n < 5000) begin
      tick();
      n++;
    end
    chk(nm, n_out, want);
  endtask

  task automatic rst_state(input string t);
    chk({t, "_ctl"}, {in_ready, div_start, out_valid, busy, out_dbz, out_ovf, out_timeout}, 7'b1000000);
    chk({t, "_div"}, {div_dividend, div_divisor}, 0);
    chk({t, "_out"}, {out_quotient, out_rem}, 0);
  endtask

  typedef struct {logic [11:0] a; logic [5:0] b; logic [15:0] exp; int st;} vec_t;
  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] res;
    int s0, base, n, a, b;
    tbl[0] = '{12'd693, 6'd11, {6'd63, 7'd0, 3'b000}, 2};
    tbl[1] = '{12'd1685, 6'd31, {6'd54, 7'd11, 3'b000}, 2};
    tbl[2] = '{12'd151, 6'd26, {6'd5, 7'd21, 3'b000}, 2};
    tbl[3] = '{12'd24, 6'd1, {6'd24, 7'd0, 3'b000}, 2};
    tbl[4] = '{12'd512, 6'd16, {6'd32, 7'd0, 3'b000}, 2};
    tbl[5] = '{12'd100, 6'd0, {6'd63, 7'd0, 3'b100}, 0};
    tbl[6] = '{12'd1024, 6'd16, {6'd63, 7'd127, 3'b010}, 0};
    tbl[7] = '{12'd4031, 6'd63, {6'd63, 7'd62, 3'b000}, 2};
    tbl[8] = '{12'd4032, 6'd63, {6'd63, 7'd127, 3'b010}, 0};
    tbl[9] = '{12'd0, 6'd1, {6'd0, 7'd0, 3'b000}, 2};

    repeat (3) tick();
    rst_state("rst_hold");
    rst_n = 1;
    tick();
    rst_state("rst_rel");

    foreach (tbl[i]) begin
      s0 = start_cnt;
      push(tbl[i].a, tbl[i].b);
      collect(res);
      chk($sformatf("vec%0d_res", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_starts", i), start_cnt - s0, tbl[i].st);
    end

    lat = 0;
    push(12'd693, 6'd11);
    chk("lat_pop", {div_start, out_valid}, 2'b00);
    tick();
    chk("lat_start1", {div_start, out_valid}, 2'b10);
    chk("lat_operands", {div_dividend, div_divisor}, {12'd693, 6'd11});
    tick();
    chk("lat_start2", {div_start, out_valid}, 2'b10);
    tick();
    chk("lat_wait", {div_start, out_valid}, 2'b00);
    tick();
    chk("lat_result", {div_start, out_valid}, 2'b01);
    collect(res);
    chk("lat_res", res, {6'd63, 7'd0, 3'b000});

    s0 = start_cnt;
    push(12'd100, 6'd0);
    chk("byp_pop", out_valid, 0);
    tick();
    chk("byp_result", {out_valid, out_dbz, out_quotient, out_rem}, {1'b1, 1'b1, 6'h3F, 7'h00});
    collect(res);
    chk("byp_no_start", start_cnt - s0, 0);

    lat = 20;
    base = n_out;
    push(12'd1685, 6'd31);
    push(12'd151, 6'd26);
    push(12'd24, 6'd1);
    push(12'd512, 6'd16);
    chk("fifo_3_queued", in_ready, 1);
    push(12'd693, 6'd11);
    chk("fifo_full", {in_ready, busy}, 2'b01);
    ready_drv = 1;
    drain("queued_drain", base + 5);
    ready_drv = 0;

    base = n_out;
    push(12'd100, 6'd0);
    push(12'd1024, 6'd16);
    push(12'd5, 6'd0);
    push(12'd4095, 6'd1);
    push(12'd7, 6'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_stable", {out_valid, out_quotient, out_rem, out_dbz, out_ovf, out_timeout, in_ready},
          {1'b1, 6'h3F, 7'h00, 3'b100, 1'b0});
    end
    ready_drv = 1;
    tick();
    chk("release_1cyc", out_valid, 0);
    tick();
    chk("next_pop", {out_valid, out_ovf}, 2'b11);
    drain("hold_drain", base + 5);
    ready_drv = 0;

    hang = 1;
    push(12'd693, 6'd11);
    repeat (3) tick();
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_res", {out_quotient, out_rem, out_dbz, out_ovf, out_timeout}, {6'h3F, 7'h7F, 3'b001});
    collect(res);
    hang = 0;
    lat = 3;
    push(12'd1685, 6'd31);
    collect(res);
    chk("after_timeout", res, {6'd54, 7'd11, 3'b000});

    manual = 1;
    man_done = 1;
    push(12'd1685, 6'd31);
    repeat (13) tick();
    chk("done_high_ignored", out_valid, 0);
    man_done = 0;
    tick();
    tick();
    chk("done_low", out_valid, 0);
    man_done = 1;
    tick();
    chk("done_edge", out_valid, 1);
    collect(res);
    chk("done_edge_res", res, {6'd54, 7'd11, 3'b000});
    manual = 0;

    lat = 30;
    push(12'd693, 6'd11);
    push(12'd151, 6'd26);
    repeat (5) tick();
    rst_n = 0;
    #1;
    rst_state("rst_async");
    sb.delete();
    tick();
    rst_n = 1;
    tick();
    rst_state("rst_after");
    lat = 2;
    push(12'd24, 6'd1);
    collect(res);
    chk("post_reset_job", res, {6'd24, 7'd0, 3'b000});

    rnd_on = 1;
    base = n_out;
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(0, 5);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      a = (b != 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, b * 64 - 1) : $urandom_range(0, 4095);
      push(12'(a), 6'(b));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("random_drain", base + 60);
    rnd_on = 0;
    tick();
    chk("final_idle", {busy, out_valid, in_ready}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
